// File: rtl/upe_serial_rx64_if.sv
// Parallel word handoff from the serial receiver to a upe arithmetic block.
// Word transfers when data_valid and data_ready are both high at a rising clk edge.
interface upe_serial_rx64_if #(
    parameter int WIDTH = 64
) ();
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/upe_serial_rx64.sv
// Single-wire serial receiver: start bit high, WIDTH data bits LSB first, stop low.
// Delivers each good word over a valid/ready handshake; flags framing errors and overruns.
module upe_serial_rx64 #(
    parameter int WIDTH      = 64,
    parameter int BIT_PERIOD = 1252
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_in,
    upe_serial_rx64_if.master bus,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy,
    output logic [1:0]        state_o
);
    // Handshake: data_out holds a word while data_valid=1 and stays stable until
    // data_valid&data_ready at a rising edge; a load in that same cycle keeps data_valid high.

    localparam int CW = $clog2(BIT_PERIOD) + 1;
    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] HALF_CNT = CW'(BIT_PERIOD / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(BIT_PERIOD - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     bit_q;
    logic [WIDTH-1:0]  shreg_q;
    logic [WIDTH-1:0]  data_out_q;
    logic              data_valid_q;
    logic              frame_err_q;
    logic              overrun_q;
    logic              sync1_q;
    logic              rx_s_q;
    logic              rx_prev_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            sync1_q      <= 1'b0;
            rx_s_q       <= 1'b0;
            rx_prev_q    <= 1'b0;
        end else begin
            sync1_q     <= rx_in;
            rx_s_q      <= sync1_q;
            rx_prev_q   <= rx_s_q;
            frame_err_q <= 1'b0;
            if (data_valid_q && bus.data_ready) data_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (rx_s_q && !rx_prev_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    // Mid-start-bit check; a line that has already dropped was a glitch.
                    if (cnt_q == HALF_CNT) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        state_q <= rx_s_q ? DATA : IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q   <= '0;
                        shreg_q <= {rx_s_q, shreg_q[WIDTH-1:1]};
                        if (bit_q == LAST_BIT) state_q <= STOP;
                        else                   bit_q   <= bit_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (rx_s_q) begin
                            frame_err_q <= 1'b1;
                        end else if (!data_valid_q || bus.data_ready) begin
                            data_out_q   <= shreg_q;
                            data_valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign frame_err      = frame_err_q;
    assign overrun        = overrun_q;
    assign busy           = (state_q != IDLE);
    assign state_o        = state_q;
endmodule
